parking_keypad_entry: RTL and testbench
=======================================

PARKING_KEYPAD_ENTRY -- requirements
Module: parking_keypad_entry

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable cycles needed to accept a raw level change.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, maximum number of cycles allowed between digit entries.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, a synchronous active-low reset.
REQ-005 The block SHALL have port sensor_entrance_raw, input, 1 bit, the raw asynchronous entrance car sensor.
REQ-006 The block SHALL have port sensor_exit_raw, input, 1 bit, the raw asynchronous exit car sensor.
REQ-007 The block SHALL have port key_press_raw, input, 1 bit, the raw asynchronous digit-enter button.
REQ-008 The block SHALL have port key_clear_raw, input, 1 bit, the raw asynchronous clear button.
REQ-009 The block SHALL have port key_in, input, 2 bits, the digit selector, which must be stable while key_press_raw is held.
REQ-010 The block SHALL have port sensor_entrance, output, 1 bit, the debounced entrance sensor that feeds car_parking.
REQ-011 The block SHALL have port sensor_exit, output, 1 bit, the debounced exit sensor that feeds car_parking.
REQ-012 The block SHALL have port password_1, output, 2 bits, the first captured digit.
REQ-013 The block SHALL have port password_2, output, 2 bits, the second captured digit.
REQ-014 The block SHALL have port pw_ready, output, 1 bit, high while both digits are held.

Function
REQ-015 Each raw input SHALL pass through a 2-flop synchronizer; key_in SHALL be synchronized with no debounce.
REQ-016 A debounced output SHALL change only after its synchronized input has differed from it for exactly DEBOUNCE_CYCLES consecutive cycles.
REQ-017 Debounce latency SHALL be 2+DEBOUNCE_CYCLES edges from the first sampled stable raw edge to the output change; a pulse shorter than DEBOUNCE_CYCLES SHALL be filtered out.
REQ-018 An accepted press SHALL be a single-cycle rising edge of the debounced key_press; the synchronized key_in SHALL be captured in that same cycle.
REQ-019 The FSM SHALL have states IDLE, WAIT_D1, WAIT_D2 and READY.
REQ-020 From IDLE, a rising edge of debounced sensor_entrance SHALL move the FSM to WAIT_D1.
REQ-021 In WAIT_D1, an accepted press SHALL load password_1 and move the FSM to WAIT_D2.
REQ-022 In WAIT_D2, an accepted press SHALL load password_2 and move the FSM to READY.
REQ-023 pw_ready SHALL be 1 exactly while the FSM is in READY and SHALL be a registered output.
REQ-024 A timeout counter SHALL run in WAIT_D1 and WAIT_D2 and SHALL restart at 0 on state entry.
REQ-025 When the timeout counter reaches TIMEOUT_CYCLES-1, the FSM SHALL go to IDLE.
REQ-026 A debounced key_clear rising edge in any state SHALL force IDLE.
REQ-027 A debounced sensor_exit rising edge in READY SHALL force IDLE.
REQ-028 On every entry to IDLE, password_1, password_2 and pw_ready SHALL be cleared to 0.
REQ-029 Accepted presses in IDLE or READY SHALL be ignored.
REQ-030 Priority for events in the same cycle SHALL be clear, then exit/timeout, then press, then entrance.
REQ-031 A press in the same cycle as a sensor_entrance rise in IDLE SHALL NOT be captured.
REQ-032 sensor_entrance and sensor_exit SHALL pass through independent of FSM state.

Reset
REQ-033 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE.
REQ-034 While rst_n=0 at a clock edge, all outputs SHALL go to 0 and all synchronizer flops, debounce counters and the timeout counter SHALL be cleared to 0.
REQ-035 Reset asserted mid-entry SHALL discard partial digits, and the first cycle after release SHALL be IDLE.

Structure
REQ-036 Package parking_pkg SHALL hold the entry_state_t enum, DIGIT_W=2 and the default DEBOUNCE_CYCLES/TIMEOUT_CYCLES constants.
REQ-037 Synchronizer plus debounce SHALL be sub-module parking_debounce, with parameter DEBOUNCE_CYCLES and ports clk, rst_n, din, dout, instanced 4 times.

Verification
REQ-038 Scenario: raw entrance glitch of 2 cycles -> sensor_entrance stays 0 and the FSM stays in IDLE.
REQ-039 Scenario: entrance high, press key_in=1, release, press key_in=2 -> password_1=1, password_2=2, and pw_ready=1 until a sensor_exit rise, after which all are 0.
REQ-040 Scenario: entrance, one press (key_in=3), then no press for TIMEOUT_CYCLES -> IDLE and password_1 returns to 0.
REQ-041 Scenario: key_clear and key_press debounced edges in the same cycle during WAIT_D2 -> IDLE and password_2=0.
REQ-042 Scenario: rst_n=0 for 1 cycle while in READY -> all outputs 0 at the next edge.
REQ-043 Scenario: raw entrance step held steady -> sensor_entrance rises exactly 2+DEBOUNCE_CYCLES=6 edges later.

Source files
------------

// File: rtl/parking_keypad_entry_pkg.sv
// Shared types and default constants for the parking keypad entry block.
package parking_pkg;

  localparam int DIGIT_W                 = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES  = 1000;

  // Bit positions of the raw inputs inside the debounce vector
  localparam int NUM_RAW      = 4;
  localparam int IDX_ENTRANCE = 0;
  localparam int IDX_EXIT     = 1;
  localparam int IDX_PRESS    = 2;
  localparam int IDX_CLEAR    = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    READY   = 2'd3
  } entry_state_t;

endpackage

// File: rtl/parking_keypad_entry_if.sv
// Raw sensor/keypad inputs and the debounced/captured outputs of the entry block.
interface parking_keypad_entry_if;
  import parking_pkg::*;

  logic               sensor_entrance_raw;
  logic               sensor_exit_raw;
  logic               key_press_raw;
  logic               key_clear_raw;
  logic [DIGIT_W-1:0] key_in;
  logic               sensor_entrance;
  logic               sensor_exit;
  logic [DIGIT_W-1:0] password_1;
  logic [DIGIT_W-1:0] password_2;
  logic               pw_ready;

  modport master (
    output sensor_entrance_raw, sensor_exit_raw, key_press_raw, key_clear_raw, key_in,
    input  sensor_entrance, sensor_exit, password_1, password_2, pw_ready
  );

  modport slave (
    input  sensor_entrance_raw, sensor_exit_raw, key_press_raw, key_clear_raw, key_in,
    output sensor_entrance, sensor_exit, password_1, password_2, pw_ready
  );

endinterface

// File: rtl/parking_keypad_entry_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for one raw input.
module parking_debounce
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          meta_reg;
  logic          sync_reg;
  logic          dout_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      dout_reg <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      // Any cycle of agreement restarts the count, so short pulses never land
      if (sync_reg != dout_reg) begin
        if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
          dout_reg <= sync_reg;
          cnt_reg  <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign dout = dout_reg;

endmodule

// File: rtl/parking_keypad_entry.sv
// Debounces the car sensors and keypad, then collects a two-digit password per car.
module parking_keypad_entry
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  parking_keypad_entry_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [NUM_RAW-1:0] raw_vec;
  logic [NUM_RAW-1:0] db_vec;
  logic [NUM_RAW-1:0] db_prev_reg;
  logic [NUM_RAW-1:0] rise_vec;

  logic [DIGIT_W-1:0] key_meta_reg, key_sync_reg;
  entry_state_t       state_reg, state_next;
  logic [TW-1:0]      timer_reg, timer_next;
  logic [DIGIT_W-1:0] pw1_reg, pw1_next, pw2_reg, pw2_next;
  logic               pw_ready_reg, pw_ready_next;
  logic               timeout_hit, press_rise, clear_rise, exit_rise, entrance_rise;

  assign raw_vec[IDX_ENTRANCE] = bus.sensor_entrance_raw;
  assign raw_vec[IDX_EXIT]     = bus.sensor_exit_raw;
  assign raw_vec[IDX_PRESS]    = bus.key_press_raw;
  assign raw_vec[IDX_CLEAR]    = bus.key_clear_raw;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RAW; gi++) begin : g_debounce
      parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (raw_vec[gi]),
        .dout (db_vec[gi])
      );
    end
  endgenerate

  assign rise_vec      = db_vec & ~db_prev_reg;
  assign entrance_rise = rise_vec[IDX_ENTRANCE];
  assign exit_rise     = rise_vec[IDX_EXIT];
  assign press_rise    = rise_vec[IDX_PRESS];
  assign clear_rise    = rise_vec[IDX_CLEAR];
  assign timeout_hit   = ((state_reg == WAIT_D1) || (state_reg == WAIT_D2)) &&
                         (timer_reg == TW'(TIMEOUT_CYCLES - 1));

  // State, edge-history, digit-sync and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      db_prev_reg  <= '0;
      key_meta_reg <= '0;
      key_sync_reg <= '0;
      timer_reg    <= '0;
      pw1_reg      <= '0;
      pw2_reg      <= '0;
      pw_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      db_prev_reg  <= db_vec;
      key_meta_reg <= bus.key_in;
      key_sync_reg <= key_meta_reg;
      timer_reg    <= timer_next;
      pw1_reg      <= pw1_next;
      pw2_reg      <= pw2_next;
      pw_ready_reg <= pw_ready_next;
    end
  end

  // Next state: clear beats exit/timeout, which beat press, which beats entrance
  always_comb begin
    state_next = state_reg;
    if (clear_rise) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE:    if (entrance_rise) state_next = WAIT_D1;
        WAIT_D1: if (timeout_hit) state_next = IDLE;
                 else if (press_rise) state_next = WAIT_D2;
        WAIT_D2: if (timeout_hit) state_next = IDLE;
                 else if (press_rise) state_next = READY;
        READY:   if (exit_rise) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs are computed from the upcoming state so they stay registered
  always_comb begin
    pw1_next      = pw1_reg;
    pw2_next      = pw2_reg;
    pw_ready_next = (state_next == READY);
    timer_next    = '0;
    if (state_next == IDLE) begin
      pw1_next = '0;
      pw2_next = '0;
    end else begin
      if ((state_reg == WAIT_D1) && (state_next == WAIT_D2)) pw1_next = key_sync_reg;
      if ((state_reg == WAIT_D2) && (state_next == READY))   pw2_next = key_sync_reg;
      if ((state_next == state_reg) &&
          ((state_reg == WAIT_D1) || (state_reg == WAIT_D2))) timer_next = timer_reg + 1'b1;
    end
  end

  assign bus.sensor_entrance = db_vec[IDX_ENTRANCE];
  assign bus.sensor_exit     = db_vec[IDX_EXIT];
  assign bus.password_1      = pw1_reg;
  assign bus.password_2      = pw2_reg;
  assign bus.pw_ready        = pw_ready_reg;

endmodule

// File: tb/tb_parking_keypad_entry.sv
// Directed bench for parking_keypad_entry with default debounce and timeout settings.
module tb_parking_keypad_entry;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  parking_keypad_entry_if bus ();

  parking_keypad_entry #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Hold a digit press long enough to debounce, then release it fully
  task automatic press_key(input logic [1:0] k);
    bus.key_in        = k;
    bus.key_press_raw = 1'b1;
    repeat (10) tick();
    bus.key_press_raw = 1'b0;
    repeat (10) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pw1"},   8'(bus.password_1), 8'd0);
    check({tag, "_pw2"},   8'(bus.password_2), 8'd0);
    check({tag, "_ready"}, 8'(bus.pw_ready),   8'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.sensor_entrance_raw = 1'b0;
    bus.sensor_exit_raw     = 1'b0;
    bus.key_press_raw       = 1'b0;
    bus.key_clear_raw       = 1'b0;
    bus.key_in              = 2'd0;
    repeat (3) tick();
    check_all_zero("reset");
    check("reset_ent",  8'(bus.sensor_entrance), 8'd0);
    check("reset_exit", 8'(bus.sensor_exit),     8'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    $display("txn reset done");

    // Two-cycle entrance glitch must be filtered; a press in IDLE is ignored
    bus.sensor_entrance_raw = 1'b1;
    repeat (2) tick();
    bus.sensor_entrance_raw = 1'b0;
    repeat (10) tick();
    check("glitch_ent", 8'(bus.sensor_entrance), 8'd0);
    press_key(2'd2);
    check_all_zero("glitch_idle");
    $display("txn glitch entrance filtered");

    // Entrance step: output rises exactly 6 edges after the raw change
    bus.sensor_entrance_raw = 1'b1;
    repeat (5) tick();
    check("lat_edge5", 8'(bus.sensor_entrance), 8'd0);
    tick();
    check("lat_edge6", 8'(bus.sensor_entrance), 8'd1);
    repeat (4) tick();
    $display("txn entrance latency");

    press_key(2'd1);
    check("d1_pw1",   8'(bus.password_1), 8'd1);
    check("d1_pw2",   8'(bus.password_2), 8'd0);
    check("d1_ready", 8'(bus.pw_ready),   8'd0);
    press_key(2'd2);
    check("d2_pw1",   8'(bus.password_1), 8'd1);
    check("d2_pw2",   8'(bus.password_2), 8'd2);
    check("d2_ready", 8'(bus.pw_ready),   8'd1);
    bus.sensor_entrance_raw = 1'b0;
    repeat (10) tick();
    check("ready_hold", 8'(bus.pw_ready), 8'd1);
    $display("txn digits 1,2 captured");

    bus.sensor_exit_raw = 1'b1;
    repeat (10) tick();
    check("exit_pass", 8'(bus.sensor_exit), 8'd1);
    check_all_zero("exit");
    bus.sensor_exit_raw = 1'b0;
    repeat (10) tick();
    $display("txn exit clears");

    // Timeout: WAIT_D2 entered 7 edges into the press, leaves 1000 edges later
    bus.sensor_entrance_raw = 1'b1;
    repeat (10) tick();
    press_key(2'd3);
    check("to_pw1", 8'(bus.password_1), 8'd3);
    repeat (986) tick();
    check("to_before", 8'(bus.password_1), 8'd3);
    tick();
    check("to_after", 8'(bus.password_1), 8'd0);
    $display("txn timeout");

    // Clear and press debounce in the same cycle during WAIT_D2
    bus.sensor_entrance_raw = 1'b0;
    repeat (10) tick();
    bus.sensor_entrance_raw = 1'b1;
    repeat (10) tick();
    press_key(2'd1);
    check("clr_pw1_pre", 8'(bus.password_1), 8'd1);
    bus.key_in        = 2'd2;
    bus.key_clear_raw = 1'b1;
    bus.key_press_raw = 1'b1;
    repeat (10) tick();
    check_all_zero("clear");
    bus.key_clear_raw = 1'b0;
    bus.key_press_raw = 1'b0;
    repeat (10) tick();
    press_key(2'd3);
    check("clr_idle_press", 8'(bus.password_1), 8'd0);
    $display("txn clear beats press");

    // Reset pulse while READY
    bus.sensor_entrance_raw = 1'b0;
    repeat (10) tick();
    bus.sensor_entrance_raw = 1'b1;
    repeat (10) tick();
    press_key(2'd1);
    press_key(2'd2);
    check("rst_ready_pre", 8'(bus.pw_ready), 8'd1);
    rst_n = 1'b0;
    tick();
    check_all_zero("rst_mid");
    check("rst_mid_ent", 8'(bus.sensor_entrance), 8'd0);
    rst_n = 1'b1;
    tick();
    check("rst_post_ready", 8'(bus.pw_ready),   8'd0);
    check("rst_post_pw1",   8'(bus.password_1), 8'd0);
    $display("txn reset in READY");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
